// File: rtl/sync_fifo_32x16_pkg.sv
// Shared constants and word type for the 32x16 synchronous FIFO.
package sync_fifo_32x16_pkg;

    localparam int FIFO_DATA_W = 32;
    localparam int FIFO_DEPTH  = 16;
    localparam int FIFO_ADDR_W = 4;

    typedef logic [FIFO_DATA_W-1:0] fifo_word_t;

endpackage : sync_fifo_32x16_pkg

// File: rtl/sync_fifo_32x16.sv
// Single-clock 32x16 FIFO with registered read data (one-cycle read latency)
// and registered full/empty flags computed from the next-state occupancy.
module sync_fifo_32x16
    import sync_fifo_32x16_pkg::*;
#(
    parameter int DATA_W = FIFO_DATA_W,
    parameter int DEPTH  = FIFO_DEPTH,
    parameter int ADDR_W = FIFO_ADDR_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dout,
    output logic              full,
    output logic              empty
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [ADDR_W-1:0] wptr_r;
    logic [ADDR_W-1:0] rptr_r;
    logic [ADDR_W:0]   count_r;
    logic [ADDR_W:0]   count_nxt_s;
    logic              wr_acc_s;
    logic              rd_acc_s;

    // Accept only what the current flags allow; a blocked side never disturbs state.
    assign wr_acc_s = wr_en && !full;
    assign rd_acc_s = rd_en && !empty;

    // Next occupancy: simultaneous accepted read and write cancel out.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + (ADDR_W+1)'(1);
            2'b01:   count_nxt_s = count_r - (ADDR_W+1)'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents are don't-care after reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (wr_acc_s) begin
            mem_r[wptr_r] <= din;
        end
    end

    // Pointers, occupancy, registered read data and flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            dout    <= '0;
            full    <= 1'b0;
            empty   <= 1'b1;
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + ADDR_W'(1);
            end
            if (rd_acc_s) begin
                dout   <= mem_r[rptr_r];
                rptr_r <= rptr_r + ADDR_W'(1);
            end
            count_r <= count_nxt_s;
            full    <= (count_nxt_s == (ADDR_W+1)'(DEPTH));
            empty   <= (count_nxt_s == (ADDR_W+1)'(0));
        end
    end

endmodule : sync_fifo_32x16

// File: tb/tb_sync_fifo_32x16.sv
// Directed and randomized bench for sync_fifo_32x16 against a queue-based model.
module tb_sync_fifo_32x16;

    logic        clk;
    logic        reset_n;
    logic [31:0] din;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] dout;
    logic        full;
    logic        empty;

    int unsigned total_checks;
    int unsigned passed_checks;

    logic [31:0] model_q [$];
    logic [31:0] exp_dout;

    sync_fifo_32x16 dut (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (din),
        .wr_en   (wr_en),
        .rd_en   (rd_en),
        .dout    (dout),
        .full    (full),
        .empty   (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_checks++;
        assert (obs === exp) passed_checks++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".dout"},  dout,  exp_dout);
        check({tag, ".full"},  {31'd0, full},  {31'd0, (model_q.size() == 16)});
        check({tag, ".empty"}, {31'd0, empty}, {31'd0, (model_q.size() == 0)});
    endtask

    // One clock of stimulus; the model applies the FIFO rules to its queue.
    task automatic step(input logic w, input logic r, input logic [31:0] d, input string tag);
        bit w_ok;
        bit r_ok;
        wr_en = w;
        rd_en = r;
        din   = d;
        w_ok  = w && (model_q.size() < 16);
        r_ok  = r && (model_q.size() > 0);
        @(posedge clk);
        if (r_ok) exp_dout = model_q.pop_front();
        if (w_ok) model_q.push_back(d);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        exp_dout      = 32'd0;
        reset_n       = 1'b0;
        wr_en         = 1'b0;
        rd_en         = 1'b0;
        din           = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        reset_n = 1'b1;

        // Idle and read while empty
        step(1'b0, 1'b0, 32'd0, "idle");
        step(1'b0, 1'b1, 32'd0, "rd_empty");

        // Single word round trip
        step(1'b1, 1'b0, 32'h5A5A_0000, "single_wr");
        step(1'b0, 1'b1, 32'd0, "single_rd");
        check("single_value", dout, 32'h5A5A_0000);

        // Fill, overflow attempt, drain
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 32'(i), "fill");
        check("full_after_16", {31'd0, full}, 32'd1);
        step(1'b1, 1'b0, 32'hDEAD_BEEF, "overflow");
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 32'd0, "drain");
            check("drain_order", dout, 32'(i));
        end

        // Pointer wrap with alternating single-word traffic
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 32'(i) * 32'h0101_0101, "wrap_wr");
            step(1'b0, 1'b1, 32'd0, "wrap_rd");
            check("wrap_value", dout, 32'(i) * 32'h0101_0101);
        end

        // Simultaneous read/write at count 8
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0, $urandom, "sim8_fill");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, $urandom, "sim8_both");
        check("sim8_count", 32'(model_q.size()), 32'd8);
        for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 32'd0, "sim8_drain");

        // Simultaneous at full: read wins, write dropped
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, $urandom, "sim16_fill");
        step(1'b1, 1'b1, 32'hCAFE_F00D, "sim16_both");
        for (int i = 0; i < 15; i++) step(1'b0, 1'b1, 32'd0, "sim16_drain");

        // Simultaneous at empty: write wins, dout unchanged
        step(1'b1, 1'b1, 32'h1234_5678, "sim0_both");
        step(1'b0, 1'b1, 32'd0, "sim0_rd");
        check("sim0_value", dout, 32'h1234_5678);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45), $urandom, "rand");
        end
        while (model_q.size() > 0) step(1'b0, 1'b1, 32'd0, "rand_drain");

        // Asynchronous reset mid-operation at count 10
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0, $urandom, "mid_fill");
        step(1'b0, 1'b1, 32'd0, "mid_rd");
        step(1'b1, 1'b0, $urandom, "mid_refill");
        wr_en = 1'b0;
        rd_en = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        model_q.delete();
        exp_dout = 32'd0;
        check_outputs("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 1'b0, 32'hA5A5_1234, "post_rst_wr");
        step(1'b0, 1'b1, 32'd0, "post_rst_rd");
        check("post_rst_value", dout, 32'hA5A5_1234);
        step(1'b0, 1'b1, 32'd0, "post_rst_empty");

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule : tb_sync_fifo_32x16

// File: doc/sync_fifo_32x16.md
# sync_fifo_32x16

Synchronous single-clock FIFO, 32 bits wide and 16 entries deep, with standard (non-first-word-fall-through) read timing. It buffers packed 32-bit words between a byte-assembly front end and an AHB write master. The producer pushes on `wr_en` and the consumer pops on `rd_en`. Popped data appears on `dout` one cycle after the pop.

## Interface
Parameters:
- `DATA_W`, default 32: word width. Fixed at 32 for this block.
- `DEPTH`, default 16: number of entries. Must be a power of two.
- `ADDR_W`, default 4: log2(`DEPTH`).

Ports:
- `clk`, input, 1: the single clock. All state changes on the rising edge.
- `reset_n`, input, 1: asynchronous, active-low reset.
- `din`, input, 32: write data, captured when a write is accepted.
- `wr_en`, input, 1: write request.
- `rd_en`, input, 1: read request.
- `dout`, output, 32: read data, registered.
- `full`, output, 1: all 16 entries occupied.
- `empty`, output, 1: no entries occupied.

## Operation
- Storage is a 16×32 register array with a 4-bit write pointer, a 4-bit read pointer and a 5-bit occupancy count (0..16).
- Accepted write = `wr_en && !full`. On an accepted write: `mem[wptr] <= din`, then `wptr` increments.
- Accepted read = `rd_en && !empty`. On an accepted read: `dout <= mem[rptr]`, then `rptr` increments.
- Both pointers wrap naturally from 15 to 0 (modulo-16 arithmetic).
- Count update per edge:
  - +1 for an accepted write only.
  - −1 for an accepted read only.
  - Unchanged when both or neither are accepted.
- Flags are registered and derived from the next-state count: `full` = (count == 16), `empty` = (count == 0).
- Write while `full`: ignored. Memory, `wptr` and count are unchanged, even if `rd_en` is also high that cycle. No overflow flag.
- Read while `empty`: ignored. `dout` holds its last value, even if `wr_en` is also high that cycle. No underflow flag.
- Simultaneous accepted read and write at any intermediate occupancy (1..15): both happen and the count is unchanged.
- When no read is accepted, `dout` holds its previous value.
- Reset (asynchronous assert, any time, including mid-transfer):
  - pointers = 0, count = 0;
  - `empty` = 1, `full` = 0, `dout` = 0;
  - memory contents are don't-care.
- Reset deassertion is sampled synchronously. The first operation is accepted on the first rising edge with `reset_n` high.

## Timing
- Read latency is 1 cycle: with `rd_en` high in cycle N (not empty), `dout` is valid in cycle N+1 and holds until the next accepted read. Consumers register `rd_en` to qualify `dout`.
- Write to visibility: a write accepted at edge N clears `empty` after edge N. A read can be issued in cycle N+1, and its data appears in cycle N+2.
- `full` asserts after the edge that accepts the 16th write. It clears after the edge of the first accepted read.
- `empty` asserts after the edge of the read that takes the last word.
- `full` and `empty` are never high together.
- There are no combinational paths from inputs to outputs.

## Structure
- Shared package holds:
  - `FIFO_DATA_W` = 32, `FIFO_DEPTH` = 16, `FIFO_ADDR_W` = 4;
  - a `fifo_word_t` 32-bit typedef.
- One flat module with no sub-modules. The memory is an inferred register array, or LUTRAM with a registered output.
- Parent wrappers instantiate this block with `clk`/`reset_n` connected directly.

## Test plan
- Reset, then idle: `empty`=1, `full`=0, `dout`=0. A `rd_en` pulse leaves `dout`=0 and `empty`=1.
- Single word: write 0x5A5A_0000 at edge N, giving `empty`=0 from cycle N+1. `rd_en` in cycle N+1 gives `dout`=0x5A5A_0000 in N+2 and `empty`=1 again.
- Fill: write 0x0..0xF, giving `full`=1 after the 16th write. A 17th write of 0xDEAD_BEEF is dropped. Reading 16 words returns 0x0..0xF in order, with `full` clearing after the first read.
- Pointer wrap: alternately write and read 40 words with values i*0x0101_0101. Every word returns in order, with the count never exceeding 1.
- Simultaneous ops:
  - At count 8, `wr_en`+`rd_en` for 4 cycles: the count stays 8 and data order is preserved.
  - At count 16, both high: the read is accepted and the write is dropped, leaving count 15.
  - At count 0, both high: the write is accepted, the read is ignored, `dout` is unchanged and the count becomes 1.
- Mid-operation reset: with count 10, assert `reset_n`=0 asynchronously between edges. `empty`=1, `full`=0 and `dout`=0 immediately. After release, a new write and read returns only the new word.
